// File: rtl/reg_mask_encoder.sv
// reg_mask_encoder: drains a register mask as ascending register indices, one per handshake.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   mask handshake; in_mask is taken only when both are high
//   out_valid/out_ready index handshake; out_idx is the lowest pending bit, out_last marks the final one
//   done                one-cycle pulse after a mask is fully drained, including an empty mask
//   count               indices emitted for the current or most recent mask
module reg_mask_encoder #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 5,
  parameter int SKIP_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_idx,
  output logic             out_last,
  output logic             done,
  output logic [SIZE:0]    count
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] pending, eff, rest;
  logic accept, hs;
  // x0 is hardwired zero, so it is dropped before it can ever be emitted
  assign eff = SKIP_ZERO != 0 ? in_mask & ~WIDTH'(1) : in_mask;
  // pending with its lowest set bit cleared
  assign rest = pending & (pending - WIDTH'(1));
  assign in_ready = state == IDLE;
  assign out_valid = state == EMIT;
  assign accept = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  assign out_last = |pending && ~|rest;
  always_comb begin
    out_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (pending[i]) out_idx = SIZE'(i);
  end
  always_comb
    state_nx = state == IDLE ? (accept && |eff ? EMIT : IDLE) : (hs && out_last ? IDLE : EMIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      if (accept) pending <= eff;
      else if (hs) pending <= rest;
      if (accept) count <= '0;
      else if (hs) count <= count + (SIZE+1)'(1);
      done <= (accept && ~|eff) || (hs && out_last);
    end
endmodule

// File: tb/tb_reg_mask_encoder.sv
// tb_reg_mask_encoder: directed table-driven bench for reg_mask_encoder
module tb_reg_mask_encoder;
  logic clk = 0, rst = 1, in_valid = 0, in_valid0 = 0, out_ready = 1;
  logic [31:0] in_mask = '0;
  logic in_ready, out_valid, out_last, done, in_ready0, out_valid0, out_last0, done0;
  logic [4:0] out_idx, out_idx0;
  logic [5:0] count, count0;
  int checks = 0, failures = 0;

  reg_mask_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .done(done), .count(count)
  );
  reg_mask_encoder #(.SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_mask(in_mask),
    .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0), .out_last(out_last0),
    .done(done0), .count(count0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    bit          rnd;
    int          n;
    logic [4:0]  first;
    logic [4:0]  final_idx;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [31:0] m);
    for (int i = 0; i < 32; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  task automatic offer(input logic [31:0] m);
    int b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("offer_ready", 32'(in_ready), 1);
    in_valid = 1;
    in_mask = m;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain(input vec_t v);
    logic [31:0] rem, acc;
    logic [4:0] first, last_i;
    logic [5:0] held;
    int n, b;
    bit stalled;
    rem = v.mask & ~32'h1;
    acc = '0;
    first = '0;
    last_i = '0;
    held = '0;
    n = 0;
    b = 0;
    stalled = 0;
    offer(v.mask);
    while (!done && b < 100) begin
      if (out_valid) begin
        chk("idx", 32'(out_idx), lowest(rem));
        chk("last", 32'(out_last), 32'($countones(rem) == 1));
        chk("in_ready_emit", 32'(in_ready), 0);
        if (stalled) chk("count_hold", 32'(count), 32'(held));
        out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          if (n == 0) first = out_idx;
          last_i = out_idx;
          rem[out_idx] = 1'b0;
          acc[out_idx] = 1'b1;
          n++;
        end
        stalled = !out_ready;
        held = count;
      end else chk("valid_or_done", 32'(out_valid | done), 1);
      @(negedge clk);
      b++;
    end
    chk("done_seen", 32'(done), 1);
    chk("count", 32'(count), 32'(v.n));
    chk("decoded_or", acc, v.mask & ~32'h1);
    chk("valid_at_done", 32'(out_valid), 0);
    chk("ready_at_done", 32'(in_ready), 1);
    if (v.n > 0) begin
      chk("first_idx", 32'(first), 32'(v.first));
      chk("final_idx", 32'(last_i), 32'(v.final_idx));
    end
    out_ready = 1;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("count_after_done", 32'(count), 32'(v.n));
  endtask

  initial begin
    vecs[0] = '{32'h8000_0002, 1'b0, 2, 5'd1, 5'd31};
    vecs[1] = '{32'h0000_0001, 1'b0, 0, 5'd0, 5'd0};
    vecs[2] = '{32'hFFFF_FFFE, 1'b1, 31, 5'd1, 5'd31};
    vecs[3] = '{32'h0000_0110, 1'b0, 2, 5'd4, 5'd8};
    vecs[4] = '{32'h0000_0000, 1'b0, 0, 5'd0, 5'd0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 31, 5'd1, 5'd31};
    vecs[6] = '{32'h0001_0000, 1'b0, 1, 5'd16, 5'd16};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) drain(vecs[i]);

    // x0 kept when SKIP_ZERO=0
    in_valid0 = 1;
    in_mask = 32'h1;
    @(negedge clk);
    in_valid0 = 0;
    chk("sz0_valid", 32'(out_valid0), 1);
    chk("sz0_idx", 32'(out_idx0), 0);
    chk("sz0_last", 32'(out_last0), 1);
    @(negedge clk);
    chk("sz0_done", 32'(done0), 1);
    chk("sz0_count", 32'(count0), 1);
    chk("sz0_valid_off", 32'(out_valid0), 0);
    @(negedge clk);

    // back-to-back masks with in_valid held high
    in_valid = 1;
    in_mask = 32'h110;
    @(negedge clk);
    chk("b2b_idx4", 32'(out_idx), 4);
    chk("b2b_last4", 32'(out_last), 0);
    in_mask = 32'h4;
    @(negedge clk);
    chk("b2b_idx8", 32'(out_idx), 8);
    chk("b2b_last8", 32'(out_last), 1);
    @(negedge clk);
    chk("b2b_done1", 32'(done), 1);
    chk("b2b_ready", 32'(in_ready), 1);
    chk("b2b_count1", 32'(count), 2);
    @(negedge clk);
    in_valid = 0;
    chk("b2b_valid2", 32'(out_valid), 1);
    chk("b2b_idx2", 32'(out_idx), 2);
    chk("b2b_last2", 32'(out_last), 1);
    chk("b2b_done_low", 32'(done), 0);
    chk("b2b_count_clr", 32'(count), 0);
    @(negedge clk);
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_count2", 32'(count), 1);
    @(negedge clk);
    chk("b2b_done2_off", 32'(done), 0);

    // asynchronous reset while stalled on idx 5
    out_ready = 0;
    offer(32'hE0);
    repeat (2) @(negedge clk);
    chk("stall_idx5", 32'(out_idx), 5);
    chk("stall_valid", 32'(out_valid), 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_done", 32'(done), 0);
    chk("arst_count", 32'(count), 0);
    repeat (2) @(negedge clk);
    chk("arst_no_done", 32'(done), 0);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("post_rst_no_done", 32'(done), 0);
    drain('{32'h0000_0008, 1'b0, 1, 5'd3, 5'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_mask_encoder.md
Name: reg_mask_encoder

Overview:
- Other direction of the 5-to-32 one-hot write-enable decoder in the register file.
- Accepts a 32-bit register mask (one bit per architectural register) and serially encodes it back into 5-bit register indices, one per cycle, lowest index first.
- Uses valid/ready handshakes on both sides.
- Used for register-file dump/debug read-out and for draining multi-register scoreboard masks into a read port.

Parameters:
- WIDTH, 32, mask width (number of registers).
- SIZE, 5, index width; WIDTH == 2**SIZE.
- SKIP_ZERO, 1, when 1 bit 0 (x0, hardwired zero) is cleared on accept and never emitted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  mask offered.
- in_ready  out  1  block can accept a mask (high only in IDLE).
- in_mask  in  WIDTH  register mask; sampled only on in_valid && in_ready.
- out_valid  out  1  out_idx holds a valid register index.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  SIZE  index of the lowest remaining set bit.
- out_last  out  1  out_idx is the final index of the current mask.
- done  out  1  one-cycle pulse: current mask fully drained (also for an empty mask).
- count  out  SIZE+1  indices emitted for the current/most recent mask.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE, pending register = 0.
  - in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, done = 0, count = 0.
  - Reset mid-drain discards remaining bits and produces no done pulse.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - EMIT: in_ready = 0, out_valid = 1.
- Accept: in_valid && in_ready at edge N.
  - pending <= in_mask, with bit 0 forced to 0 when SKIP_ZERO = 1.
  - count <= 0.
  - If the effective mask is non-zero, go to EMIT; first out_valid appears in cycle N+1.
  - If the effective mask is zero, stay IDLE and pulse done in cycle N+1; out_valid never rises.
- EMIT outputs:
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
- EMIT handshake: on out_valid && out_ready:
  - Clear that bit in pending; count <= count + 1.
  - If out_last, go to IDLE; done = 1 and in_ready = 1 in the next cycle.
- Back-pressure: while out_valid && !out_ready, out_idx, out_last and count hold stable indefinitely. out_valid never drops without a handshake.
- Throughput: one index per cycle with out_ready held high. A mask with k set bits drains in k cycles; 0xFFFF_FFFE takes 31 cycles.
- Back-to-back masks: a new mask may be accepted in the done cycle (IDLE, in_ready = 1). The done pulse still lasts exactly one cycle, and count clears at the edge ending that cycle.
- in_mask and in_valid are ignored while in EMIT.
- count holds its final value after done until the next accept. Width SIZE+1 covers 32.
- Outputs out_valid, in_ready, done and count are registered or decoded directly from registered state. out_idx and out_last may be combinational from the pending register only, with no input-to-output combinational path.
- Round-trip property: OR of the 5-to-32 decoded out_idx over one drain equals the effective accepted mask.

Test Plan:
- Reset, then mask 0x8000_0002 with out_ready = 1:
  - Response: out_idx 1 (last = 0), then 31 (last = 1) on consecutive cycles.
  - done pulses 1 cycle after the final handshake; count = 2.
- Mask 0x0000_0001 with SKIP_ZERO = 1:
  - Response: no out_valid; done in cycle N+1; count = 0.
- Same mask 0x0000_0001 with SKIP_ZERO = 0:
  - Response: single idx 0 with out_last = 1.
- Mask 0xFFFF_FFFE with random out_ready:
  - Response: idx 1..31 strictly ascending; each stable while stalled; in_ready = 0 throughout.
  - count = 31; decoded-OR equals 0xFFFF_FFFE.
- Masks 0x0000_0110 then 0x0000_0004, second offered with in_valid held high:
  - Response: idx 4, 8, then accept in the done cycle, then idx 2.
  - Two done pulses; count = 2 then 1.
- Assert rst asynchronously mid-edge while stalled on idx 5 of mask 0x0000_00E0:
  - Response: out_valid = 0 and in_ready = 1 immediately, no done.
  - After release, mask 0x0000_0008 yields idx 3 only.
